cam_masked_mc: RTL and testbench

- Parametrised content-addressable memory; successor to the fixed 32x32 CAM.
- Adds per-entry valid bits, invalidate and flush, ternary (masked) search, multi-hit detection and an occupancy count.
- Search is pipelined (2 cycles) so depth can grow without a long compare-plus-encode path.
- Sits beside the hash/lookup engines as the key-to-index store for the pandas offload datapath.

---
 rtl/cam_masked_mc_pkg.sv | 18 +
 rtl/cam_masked_mc_prio_enc.sv | 30 +++
 rtl/cam_masked_mc.sv | 127 ++++++++++++
 tb/tb_cam_masked_mc.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_masked_mc_pkg.sv
// Shared types and helpers for the masked, multi-hit CAM.
package cam_pkg;

  localparam int unsigned CAM_DATA_WIDTH = 32;
  localparam int unsigned CAM_DEPTH_LOG2 = 5;
  localparam int unsigned DEPTH          = 2 ** CAM_DEPTH_LOG2;

  // Typedefs are at the package defaults; non-default instances use explicit widths.
  typedef logic [CAM_DEPTH_LOG2-1:0] cam_idx_t;
  typedef logic [CAM_DATA_WIDTH-1:0] cam_data_t;
  typedef logic [DEPTH-1:0]          cam_vec_t;
  typedef logic [CAM_DEPTH_LOG2:0]   cam_cnt_t;

  function automatic int unsigned cam_depth(input int unsigned depth_log2);
    return 32'd1 << depth_log2;
  endfunction

endpackage

// File: rtl/cam_masked_mc_prio_enc.sv
// Lowest-index priority encoder with multi-hit flag over a CAM match vector.
module cam_prio_enc #(
  parameter int unsigned DEPTH_LOG2 = 5
) (
  input  logic [(2**DEPTH_LOG2)-1:0] match,
  output logic                       hit,
  output logic [DEPTH_LOG2-1:0]      index,
  output logic                       multi
);

  localparam int unsigned ENTRIES = 2 ** DEPTH_LOG2;

  // Scan upward: first set bit gives the index, any later set bit flags multi.
  always_comb begin
    hit   = 1'b0;
    index = '0;
    multi = 1'b0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (match[i]) begin
        if (hit) begin
          multi = 1'b1;
        end else begin
          hit   = 1'b1;
          index = DEPTH_LOG2'(i);
        end
      end
    end
  end

endmodule

// File: rtl/cam_masked_mc.sv
// Parametrised ternary CAM: valid bits, invalidate/flush, 2-stage search, occupancy.
module cam_masked_mc
  import cam_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  read_i,
  input  logic [DEPTH_LOG2-1:0] read_index_i,
  input  logic                  write_i,
  input  logic [DEPTH_LOG2-1:0] write_index_i,
  input  logic [DATA_WIDTH-1:0] write_data_i,
  input  logic                  invalidate_i,
  input  logic [DEPTH_LOG2-1:0] invalidate_index_i,
  input  logic                  flush_i,
  input  logic                  search_i,
  input  logic [DATA_WIDTH-1:0] search_data_i,
  input  logic [DATA_WIDTH-1:0] search_mask_i,
  output logic                  read_valid_o,
  output logic [DATA_WIDTH-1:0] read_value_o,
  output logic                  read_hit_o,
  output logic                  search_valid_o,
  output logic                  search_hit_o,
  output logic [DEPTH_LOG2-1:0] search_index_o,
  output logic                  search_multi_o,
  output logic [DEPTH_LOG2:0]   occupancy_o
);

  localparam int unsigned ENTRIES = cam_depth(DEPTH_LOG2);

  logic [DATA_WIDTH-1:0] mem [ENTRIES];
  logic [ENTRIES-1:0]    valid;
  logic [ENTRIES-1:0]    match_c;
  logic [ENTRIES-1:0]    s1_match;
  logic                  s1_valid;
  logic                  enc_hit;
  logic [DEPTH_LOG2-1:0] enc_index;
  logic                  enc_multi;

  // Data array: written on request, never reset.
  always_ff @(posedge clk) begin
    if (write_i) mem[write_index_i] <= write_data_i;
  end

  // Valid bits: flush beats invalidate beats write (later NBA wins on the same bit).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= '0;
    end else if (flush_i) begin
      valid <= '0;
    end else begin
      if (write_i)      valid[write_index_i]      <= 1'b1;
      if (invalidate_i) valid[invalidate_index_i] <= 1'b0;
    end
  end

  // Read port: one-cycle latency, read-before-write, result held between strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      read_valid_o <= 1'b0;
      read_value_o <= '0;
      read_hit_o   <= 1'b0;
    end else begin
      read_valid_o <= read_i;
      if (read_i) begin
        read_value_o <= mem[read_index_i];
        read_hit_o   <= valid[read_index_i];
      end
    end
  end

  // Ternary compare of the key against every valid entry.
  always_comb begin
    match_c = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      match_c[i] = valid[i] & (((mem[i] ^ search_data_i) & search_mask_i) == '0);
    end
  end

  // Search stage 1: register the match vector.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_match <= '0;
    end else begin
      s1_valid <= search_i;
      if (search_i) s1_match <= match_c;
    end
  end

  cam_prio_enc #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_prio_enc (
    .match(s1_match),
    .hit  (enc_hit),
    .index(enc_index),
    .multi(enc_multi)
  );

  // Search stage 2: register the encoded result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      search_valid_o <= 1'b0;
      search_hit_o   <= 1'b0;
      search_index_o <= '0;
      search_multi_o <= 1'b0;
    end else begin
      search_valid_o <= s1_valid;
      if (s1_valid) begin
        search_hit_o   <= enc_hit;
        search_index_o <= enc_index;
        search_multi_o <= enc_multi;
      end
    end
  end

  // Occupancy: popcount of the registered valid vector.
  always_comb begin
    occupancy_o = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      occupancy_o = occupancy_o + {{DEPTH_LOG2{1'b0}}, valid[i]};
    end
  end

endmodule

// File: tb/tb_cam_masked_mc.sv
// Scoreboard bench for cam_masked_mc: directed vectors, queued expectations.
module tb_cam_masked_mc;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          read_i;
  logic [AW-1:0] read_index_i;
  logic          write_i;
  logic [AW-1:0] write_index_i;
  logic [DW-1:0] write_data_i;
  logic          invalidate_i;
  logic [AW-1:0] invalidate_index_i;
  logic          flush_i;
  logic          search_i;
  logic [DW-1:0] search_data_i;
  logic [DW-1:0] search_mask_i;
  logic          read_valid_o;
  logic [DW-1:0] read_value_o;
  logic          read_hit_o;
  logic          search_valid_o;
  logic          search_hit_o;
  logic [AW-1:0] search_index_o;
  logic          search_multi_o;
  logic [AW:0]   occupancy_o;

  typedef struct packed {
    logic [DW-1:0] value;
    logic          hit;
  } rd_exp_t;

  typedef struct packed {
    logic          hit;
    logic [AW-1:0] index;
    logic          multi;
  } sr_exp_t;

  rd_exp_t rd_q[$];
  sr_exp_t sr_q[$];
  int checks = 0;
  int errors = 0;

  cam_masked_mc #(
    .DATA_WIDTH(DW),
    .DEPTH_LOG2(AW)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .read_i            (read_i),
    .read_index_i      (read_index_i),
    .write_i           (write_i),
    .write_index_i     (write_index_i),
    .write_data_i      (write_data_i),
    .invalidate_i      (invalidate_i),
    .invalidate_index_i(invalidate_index_i),
    .flush_i           (flush_i),
    .search_i          (search_i),
    .search_data_i     (search_data_i),
    .search_mask_i     (search_mask_i),
    .read_valid_o      (read_valid_o),
    .read_value_o      (read_value_o),
    .read_hit_o        (read_hit_o),
    .search_valid_o    (search_valid_o),
    .search_hit_o      (search_hit_o),
    .search_index_o    (search_index_o),
    .search_multi_o    (search_multi_o),
    .occupancy_o       (occupancy_o)
  );

  always #5 clk = ~clk;

  // Monitor: pop and compare whenever the DUT strobes a result.
  always @(negedge clk) begin
    if (read_valid_o) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL read_unexpected: got value=%h hit=%0b, required no read strobe",
                 read_value_o, read_hit_o);
      end else begin
        rd_exp_t e;
        e = rd_q.pop_front();
        if (read_value_o !== e.value || read_hit_o !== e.hit) begin
          errors++;
          $display("FAIL read: got value=%h hit=%0b, required value=%h hit=%0b",
                   read_value_o, read_hit_o, e.value, e.hit);
        end
      end
    end
    if (search_valid_o) begin
      checks++;
      if (sr_q.size() == 0) begin
        errors++;
        $display("FAIL search_unexpected: got hit=%0b idx=%0d multi=%0b, required no search strobe",
                 search_hit_o, search_index_o, search_multi_o);
      end else begin
        sr_exp_t s;
        s = sr_q.pop_front();
        if (search_hit_o !== s.hit || search_index_o !== s.index || search_multi_o !== s.multi) begin
          errors++;
          $display("FAIL search: got hit=%0b idx=%0d multi=%0b, required hit=%0b idx=%0d multi=%0b",
                   search_hit_o, search_index_o, search_multi_o, s.hit, s.index, s.multi);
        end
      end
    end
  end

  task automatic clear_inputs();
    read_i = 1'b0; read_index_i = '0;
    write_i = 1'b0; write_index_i = '0; write_data_i = '0;
    invalidate_i = 1'b0; invalidate_index_i = '0;
    flush_i = 1'b0;
    search_i = 1'b0; search_data_i = '0; search_mask_i = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic set_write(input logic [AW-1:0] idx, input logic [DW-1:0] d);
    write_i = 1'b1; write_index_i = idx; write_data_i = d;
  endtask

  task automatic set_read(input logic [AW-1:0] idx, input logic [DW-1:0] ev, input logic eh);
    rd_exp_t e;
    read_i = 1'b1; read_index_i = idx;
    e.value = ev; e.hit = eh;
    rd_q.push_back(e);
  endtask

  task automatic set_search(input logic [DW-1:0] key, input logic [DW-1:0] mask,
                            input logic eh, input logic [AW-1:0] ei, input logic em);
    sr_exp_t s;
    search_i = 1'b1; search_data_i = key; search_mask_i = mask;
    s.hit = eh; s.index = ei; s.multi = em;
    sr_q.push_back(s);
  endtask

  task automatic check_occ(input string name, input int exp);
    checks++;
    if (occupancy_o !== (AW+1)'(exp)) begin
      errors++;
      $display("FAIL %s: got occupancy=%0d, required %0d", name, occupancy_o, exp);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if (read_valid_o !== 1'b0 || read_value_o !== '0 || read_hit_o !== 1'b0 ||
        search_valid_o !== 1'b0 || search_hit_o !== 1'b0 || search_index_o !== '0 ||
        search_multi_o !== 1'b0 || occupancy_o !== '0) begin
      errors++;
      $display("FAIL %s: got rv=%0b val=%h rh=%0b sv=%0b sh=%0b si=%0d sm=%0b occ=%0d, required all 0",
               name, read_valid_o, read_value_o, read_hit_o, search_valid_o, search_hit_o,
               search_index_o, search_multi_o, occupancy_o);
    end
  endtask

  function automatic logic [DW-1:0] fill_val(input int i);
    return {8'(i), 8'hC3, 8'(i), 8'h3C};
  endfunction

  initial begin
    clear_inputs();
    reset_n = 1'b0;
    idle(3);
    check_outputs_zero("reset_state");
    reset_n = 1'b1;
    idle(1);

    // Duplicate key: lowest index wins, multi set.
    set_write(5'd3, 32'hDEADBEEF); tick();
    set_write(5'd7, 32'hDEADBEEF); tick();
    set_search(32'hDEADBEEF, 32'hFFFFFFFF, 1'b1, 5'd3, 1'b1); tick();
    idle(3);
    check_occ("occ_two", 2);

    // Invalidate keeps data, removes match.
    invalidate_i = 1'b1; invalidate_index_i = 5'd3; tick();
    set_search(32'hDEADBEEF, 32'hFFFFFFFF, 1'b1, 5'd7, 1'b0); tick();
    set_read(5'd3, 32'hDEADBEEF, 1'b0); tick();
    idle(3);
    check_occ("occ_after_inval", 1);

    // Ternary match on the upper half only.
    set_write(5'd5, 32'h12340000); tick();
    set_search(32'h1234FFFF, 32'hFFFF0000, 1'b1, 5'd5, 1'b0); tick();
    set_search(32'h1234FFFF, 32'hFFFFFFFF, 1'b0, 5'd0, 1'b0); tick();
    idle(3);

    // Same-cycle write is invisible to search; then back-to-back searches.
    set_write(5'd9, 32'hA5A5A5A5);
    set_search(32'hA5A5A5A5, 32'hFFFFFFFF, 1'b0, 5'd0, 1'b0); tick();
    set_search(32'hA5A5A5A5, 32'hFFFFFFFF, 1'b1, 5'd9, 1'b0); tick();
    set_search(32'hDEADBEEF, 32'hFFFFFFFF, 1'b1, 5'd7, 1'b0); tick();
    idle(3);
    check_occ("occ_three", 3);

    // Write and invalidate same index: data updated, entry invalid.
    set_write(5'd2, 32'h0BADF00D);
    invalidate_i = 1'b1; invalidate_index_i = 5'd2; tick();
    set_read(5'd2, 32'h0BADF00D, 1'b0); tick();
    idle(2);
    check_occ("occ_wr_inv_same", 3);

    // Fill every entry; read-before-write on entry 7.
    for (int i = 0; i < 32; i++) begin
      set_write(5'(i), fill_val(i));
      if (i == 7) set_read(5'd7, 32'hDEADBEEF, 1'b1);
      tick();
    end
    idle(1);
    check_occ("occ_full", 32);
    set_read(5'd5, fill_val(5), 1'b1); tick();
    set_search(32'h0, 32'h0, 1'b1, 5'd0, 1'b1); tick();
    set_search(fill_val(20), 32'hFFFFFFFF, 1'b1, 5'd20, 1'b0); tick();
    idle(3);

    // Flush empties the array; mask-0 search then misses.
    flush_i = 1'b1; tick();
    check_occ("occ_flushed", 0);
    set_search(32'h0, 32'h0, 1'b0, 5'd0, 1'b0); tick();
    idle(3);

    // Reset during an in-flight search: no result may appear.
    set_write(5'd1, 32'h11111111); tick();
    search_i = 1'b1; search_data_i = 32'h11111111; search_mask_i = 32'hFFFFFFFF;
    tick();
    reset_n = 1'b0;
    idle(3);
    check_outputs_zero("reset_mid_search");
    reset_n = 1'b1;
    idle(4);
    check_outputs_zero("after_reset_idle");

    checks++;
    if (rd_q.size() != 0 || sr_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d reads and %0d searches outstanding, required 0",
               rd_q.size(), sr_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
